// File: rtl/hit_miss_round_ctrl.sv
// Round sequencer for the hit-or-miss LED game.
// Requests targets, times the hit window, judges presses, keeps score.
module hit_miss_round_ctrl #(
   parameter int WIN_W    = 27,
   parameter int WIN_INIT = 100000000,
   parameter int WIN_MIN  = 25000000,
   parameter int WIN_STEP = 5000000,
   parameter int MAX_MISS = 3,
   parameter int SCORE_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic [7:0]         btn,
   input  logic [7:0]         tgt_onehot,
   output logic               tgt_req,
   output logic               led_en,
   output logic [7:0]         tgt_q,
   output logic [SCORE_W-1:0] score,
   output logic [3:0]         misses,
   output logic               hit_pulse,
   output logic               miss_pulse,
   output logic               game_over,
   output logic [2:0]         state
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_WAIT = 3'd2,
      S_SHOW = 3'd3,
      S_HIT  = 3'd4,
      S_MISS = 3'd5,
      S_OVER = 3'd6
   } state_t;

   localparam logic [WIN_W-1:0] WIN_INIT_V = (WIN_W)'(WIN_INIT);
   localparam logic [WIN_W-1:0] WIN_MIN_V  = (WIN_W)'(WIN_MIN);
   localparam logic [WIN_W:0]   WIN_THR_X  = (WIN_W+1)'(WIN_MIN + WIN_STEP);
   localparam logic [WIN_W:0]   WIN_STEP_X = (WIN_W+1)'(WIN_STEP);
   localparam logic [3:0]       MAX_MISS_V = 4'(MAX_MISS);

   state_t               state_q, state_d;
   logic                 start_d_q;
   logic [7:0]           btn_d_q;
   logic [7:0]           tgt_sel_q, tgt_sel_d;
   logic [WIN_W-1:0]     cnt_q, cnt_d;
   logic [WIN_W-1:0]     window_q, window_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [3:0]           misses_q, misses_d;
   logic                 led_en_q, led_en_d;
   logic                 tgt_req_q, tgt_req_d;
   logic                 hit_pulse_q, hit_pulse_d;
   logic                 miss_pulse_q, miss_pulse_d;
   logic                 game_over_q, game_over_d;

   logic                 start_rise;
   logic [7:0]           btn_rise;
   logic                 tgt_valid;
   logic [WIN_W:0]       window_x;

   assign start_rise = start & ~start_d_q;
   assign btn_rise   = btn & ~btn_d_q;
   assign tgt_valid  = (tgt_onehot != 8'd0) &&
                       ((tgt_onehot & (tgt_onehot - 8'd1)) == 8'd0);
   assign window_x   = {1'b0, window_q};

   // Next-state, round bookkeeping and registered Moore outputs
   always_comb begin
      state_d   = state_q;
      tgt_sel_d = tgt_sel_q;
      cnt_d     = cnt_q;
      window_d  = window_q;
      score_d   = score_q;
      misses_d  = misses_q;
      case (state_q)
         S_IDLE, S_OVER: begin
            if (start_rise) begin
               score_d  = '0;
               misses_d = '0;
               window_d = WIN_INIT_V;
               state_d  = S_REQ;
            end
         end
         S_REQ: state_d = S_WAIT;
         S_WAIT: begin
            if (tgt_valid) begin
               tgt_sel_d = tgt_onehot;
               cnt_d     = window_q - (WIN_W)'(1);
               state_d   = S_SHOW;
            end else begin
               state_d = S_REQ;
            end
         end
         S_SHOW: begin
            if (btn_rise != 8'd0) begin
               if (btn_rise == tgt_sel_q) begin
                  state_d = S_HIT;
                  if (score_q != '1)
                     score_d = score_q + (SCORE_W)'(1);
                  if (window_x < WIN_THR_X)
                     window_d = WIN_MIN_V;
                  else
                     window_d = (WIN_W)'(window_x - WIN_STEP_X);
               end else begin
                  state_d  = S_MISS;
                  misses_d = misses_q + 4'd1;
               end
            end else if (cnt_q == '0) begin
               state_d  = S_MISS;
               misses_d = misses_q + 4'd1;
            end else begin
               cnt_d = cnt_q - (WIN_W)'(1);
            end
         end
         S_HIT:  state_d = S_REQ;
         S_MISS: state_d = (misses_q == MAX_MISS_V) ? S_OVER : S_REQ;
         default: state_d = S_IDLE;
      endcase
      led_en_d     = (state_d == S_SHOW);
      tgt_req_d    = (state_d == S_REQ);
      hit_pulse_d  = (state_d == S_HIT);
      miss_pulse_d = (state_d == S_MISS);
      game_over_d  = (state_d == S_OVER);
   end

   // State, counters and edge-detect registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         start_d_q    <= 1'b0;
         btn_d_q      <= 8'd0;
         tgt_sel_q    <= 8'd0;
         cnt_q        <= '0;
         window_q     <= WIN_INIT_V;
         score_q      <= '0;
         misses_q     <= 4'd0;
         led_en_q     <= 1'b0;
         tgt_req_q    <= 1'b0;
         hit_pulse_q  <= 1'b0;
         miss_pulse_q <= 1'b0;
         game_over_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         start_d_q    <= start;
         btn_d_q      <= btn;
         tgt_sel_q    <= tgt_sel_d;
         cnt_q        <= cnt_d;
         window_q     <= window_d;
         score_q      <= score_d;
         misses_q     <= misses_d;
         led_en_q     <= led_en_d;
         tgt_req_q    <= tgt_req_d;
         hit_pulse_q  <= hit_pulse_d;
         miss_pulse_q <= miss_pulse_d;
         game_over_q  <= game_over_d;
      end
   end

   assign tgt_req    = tgt_req_q;
   assign led_en     = led_en_q;
   assign tgt_q      = tgt_sel_q;
   assign score      = score_q;
   assign misses     = misses_q;
   assign hit_pulse  = hit_pulse_q;
   assign miss_pulse = miss_pulse_q;
   assign game_over  = game_over_q;
   assign state      = state_q;

endmodule

// File: doc/hit_miss_round_ctrl.md
Name: hit_miss_round_ctrl

Overview:
Round sequencer for the hit-or-miss LED game. It requests a new target LED from the randomizer and opens a timed hit window. It judges player button edges against the lit LED, then keeps score and miss count. Each hit shrinks the window, and the game ends after MAX_MISS misses. It sits between the debounced button inputs, the randomizer (its tgt_req drives the randomizer's freq input) and the LED/score display logic.

Parameters:
WIN_W, 27, width of window counter and window register
WIN_INIT, 100000000, initial hit window in clk cycles (1 s at 100 MHz)
WIN_MIN, 25000000, floor of hit window
WIN_STEP, 5000000, window reduction per hit
MAX_MISS, 3, misses that end the game (1..15)
SCORE_W, 8, score width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level, debounced; rising edge starts or restarts a game
btn  in  8  level, debounced player buttons, bit i = LED i
tgt_onehot  in  8  one-hot LED selection from randomizer
tgt_req  out  1  one-cycle pulse to randomizer freq input
led_en  out  1  high while hit window open; gates LED drive
tgt_q  out  8  captured target, valid while led_en
score  out  SCORE_W  hits this game, saturating
misses  out  4  misses this game
hit_pulse  out  1  one-cycle pulse on judged hit
miss_pulse  out  1  one-cycle pulse on judged miss
game_over  out  1  high in OVER state
state  out  3  encoded state (debug)

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. All registers clear on reset: state=IDLE, every output 0, window=WIN_INIT, and the start/btn edge-detect registers = 0. Reset mid-round aborts immediately; no pulse is emitted.
- Edge detect: start_rise = start & ~start_d. btn_rise = btn & ~btn_d. Both _d registers update every cycle.
- State encodings: IDLE=0, REQ=1, WAIT=2, SHOW=3, HIT=4, MISS=5, OVER=6.
- IDLE: on start_rise, clear score and misses, set window=WIN_INIT, go to REQ.
- REQ: tgt_req=1 for exactly this cycle, then go to WAIT.
- WAIT: one cycle, allowing the randomizer output to settle. Next cycle is SHOW entry: capture tgt_q<=tgt_onehot and load cnt<=window-1.
- If the captured value is not exactly one-hot (zero or multi-bit), return to REQ. This is a retry and is not a miss.
- SHOW: led_en=1. Each cycle is evaluated in this priority order:
  (a) btn_rise!=0 and btn_rise==tgt_q -> HIT;
  (b) btn_rise!=0 otherwise (wrong button, or correct plus any other in the same cycle) -> MISS;
  (c) cnt==0 -> MISS (timeout);
  (d) else cnt<=cnt-1.
  The window therefore lasts exactly `window` cycles of led_en. A button edge in the final cycle is judged as a press, not a timeout.
- Buttons held since before SHOW entry produce no edge and are ignored. Edges outside SHOW are ignored.
- HIT (1 cycle): hit_pulse=1; score<=score+1, saturating at all-ones.
  - window<=WIN_MIN if window < WIN_MIN+WIN_STEP, else window-WIN_STEP. Compute in WIN_W+1 bits; no underflow.
  - Go to REQ.
- MISS (1 cycle): miss_pulse=1; misses<=misses+1. If misses+1==MAX_MISS go to OVER, else go to REQ.
- OVER: game_over=1, led_en=0. score, misses and tgt_q hold their values. On start_rise, clear and go to REQ, same as from IDLE.
- start_rise outside IDLE/OVER is ignored.
- led_en, tgt_req, hit_pulse, miss_pulse and game_over are registered (Moore) outputs.
- Latency: start_rise to tgt_req is 1 cycle; tgt_req to led_en is 2 cycles.

Test Plan:
Bench params: WIN_INIT=20, WIN_MIN=8, WIN_STEP=4, MAX_MISS=3. The randomizer model returns 8'h04 one cycle after tgt_req.
1. Hold rst_n=0, then release -> all outputs 0, state=0. Toggle btn -> no pulses.
2. start rise -> tgt_req 1 cycle later; led_en 2 cycles after tgt_req with tgt_q=8'h04. btn[2] rise at SHOW cycle 5 -> hit_pulse, score=1, next window 16.
3. No press -> led_en high exactly 20 cycles, then miss_pulse, misses=1, new tgt_req.
4. Wrong press: btn[5] rise -> miss. Simultaneous btn[2]|btn[5] rise -> miss. btn[2] held from before SHOW -> ignored, timeout miss. btn[2] rise on final cycle -> hit.
5. Five consecutive hits -> window lengths 20, 16, 12, 8, 8 (floor held). Model returns 8'h00 once -> extra tgt_req, no miss.
6. Three misses -> game_over=1, led_en=0, misses=3, score held. start rise -> score=0, misses=0, window=20. Assert rst_n mid-SHOW -> immediate clear, no pulse.
